sp_cmd_issuer: RTL and testbench
================================

SP_CMD_ISSUER -- requirements
Module: sp_cmd_issuer

Interface
REQ-001 Parameter NUM_UNITS, default 4, number of attached command units (2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, busy-cycle limit per unit; 0 disables timeout.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  requester has a command for unit cmd_unit.
REQ-006 cmd_unit  input  $clog2(NUM_UNITS)  target unit index.
REQ-007 cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-008 issue_new_request  output  NUM_UNITS  one-hot issue strobe to the units.
REQ-009 issue_ready  input  NUM_UNITS  per-unit ready to take a request.
REQ-010 wb_done  input  NUM_UNITS  per-unit command-complete level, held until acked.
REQ-011 wb_ack  output  NUM_UNITS  one-hot writeback acknowledge.
REQ-012 done_valid  output  1  registered completion pulse.
REQ-013 done_unit  output  $clog2(NUM_UNITS)  unit index of the completion.
REQ-014 busy  output  NUM_UNITS  per-unit outstanding-command bitmap.
REQ-015 timeout_err  output  1  sticky timeout flag.
REQ-016 timeout_unit  output  $clog2(NUM_UNITS)  first unit that timed out.

Function
REQ-017 Issue: cmd_ready = cmd_valid-independent, = !rst & !busy[cmd_unit] & issue_ready[cmd_unit]; combinational, zero latency.
REQ-018 issue_new_request[cmd_unit] high iff cmd_valid & cmd_ready; all other bits 0.
REQ-019 Accepted issue sets busy[cmd_unit] at next edge; at most one outstanding command per unit.
REQ-020 cmd_unit >= NUM_UNITS: cmd_ready 0, no strobe, no state change.
REQ-021 Writeback candidates = wb_done & busy; wb_done on a non-busy unit ignored, never acked.
REQ-022 Round-robin arbiter grants one candidate per cycle; wb_ack = grant, combinational, same cycle.
REQ-023 Priority pointer starts at unit 0; after a grant to unit i, pointer = (i+1) mod NUM_UNITS; wraps at NUM_UNITS-1 -> 0; unchanged with no grant.
REQ-024 Grant to unit i clears busy[i] at next edge; unit may be reissued from that cycle on.
REQ-025 done_valid = 1 and done_unit = i one cycle after wb_ack[i]; done_valid 0 otherwise.
REQ-026 Simultaneous issue to unit A and ack of unit B (A != B) both take effect; A == B impossible by REQ-017.
REQ-027 Per-unit 16-bit busy-cycle counter: cleared on issue, incremented each cycle busy, saturating at 0xFFFF.
REQ-028 Counter reaching TIMEOUT_CYCLES while busy, TIMEOUT_CYCLES != 0: timeout_err set, timeout_unit captured if timeout_err was 0; lowest index wins same-cycle ties.
REQ-029 timeout_err/timeout_unit sticky until rst; timeout does not clear busy or block acks.

Reset
REQ-030 On rst: busy 0, pointer 0, counters 0, done_valid 0, done_unit 0, timeout_err 0, timeout_unit 0.
REQ-031 While rst: cmd_ready, issue_new_request, wb_ack all 0; outstanding commands abandoned mid-operation.

Structure
REQ-032 Package sp_cmd_pkg holds unit-index typedef, MAX_UNITS (16) and counter-width constant (16).
REQ-033 Round-robin arbiter is sub-module sp_rr_arbiter (request vector, pointer in, one-hot grant and index out).

Verification
REQ-034 Issue unit 2, issue_ready=1111 -> issue_new_request=0100 same cycle, busy=0100 next cycle; second cmd to unit 2 -> cmd_ready 0.
REQ-035 busy=1111, wb_done=1111, pointer 0 -> wb_ack 0001,0010,0100,1000 on consecutive cycles; done_unit 0,1,2,3 one cycle later each.
REQ-036 Pointer 3, wb_done=1001 -> ack unit 3 then unit 0 (wrap).
REQ-037 wb_done=0010 with busy=0000 -> wb_ack stays 0, done_valid stays 0.
REQ-038 TIMEOUT_CYCLES=8, issue unit 1, no wb_done -> timeout_err 1, timeout_unit 1 after 8 busy cycles; later ack still clears busy; flag remains.
REQ-039 rst asserted with busy=0110 -> next cycle busy 0, outputs at reset values; cmd_ready 0 during rst.

Source files
------------

// File: rtl/sp_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_cmd_pkg
// Description : Shared types and constants for the command issuer slice:
//               unit-index type, unit-count ceiling, busy-counter width and
//               the round-robin pointer advance helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sp_cmd_pkg;

    // Largest number of command units the issuer is built for
    localparam int MAX_UNITS  = 16;
    // Width of the per-unit busy-cycle counter
    localparam int CNT_W      = 16;
    localparam int UNIT_IDX_W = $clog2(MAX_UNITS);

    typedef logic [UNIT_IDX_W-1:0] unit_idx_t;
    typedef logic [CNT_W-1:0]      busy_cnt_t;

    // Saturation value of the busy-cycle counter
    localparam busy_cnt_t CNT_SAT = '1;

    // Pointer value that follows a grant to unit idx, wrapping at n-1 -> 0
    function automatic unit_idx_t wrap_next(unit_idx_t idx, int n);
        if (int'(idx) + 1 >= n) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage : sp_cmd_pkg
`default_nettype wire

// File: rtl/sp_cmd_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : sp_cmd_issuer_if
// Description : Bundle of requester, unit and status signals of the command
//               issuer. slave = issuer side, master = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface sp_cmd_issuer_if #(
    parameter int NUM_UNITS = 4
);
    localparam int c_idx_w = $clog2(NUM_UNITS);

    // Requester side
    logic                 cmd_valid;
    logic [c_idx_w-1:0]   cmd_unit;
    logic                 cmd_ready;
    // Unit side
    logic [NUM_UNITS-1:0] issue_new_request;
    logic [NUM_UNITS-1:0] issue_ready;
    logic [NUM_UNITS-1:0] wb_done;
    logic [NUM_UNITS-1:0] wb_ack;
    // Status
    logic                 done_valid;
    logic [c_idx_w-1:0]   done_unit;
    logic [NUM_UNITS-1:0] busy;
    logic                 timeout_err;
    logic [c_idx_w-1:0]   timeout_unit;

    modport slave (
        input  cmd_valid, cmd_unit, issue_ready, wb_done,
        output cmd_ready, issue_new_request, wb_ack,
               done_valid, done_unit, busy, timeout_err, timeout_unit
    );

    modport master (
        output cmd_valid, cmd_unit, issue_ready, wb_done,
        input  cmd_ready, issue_new_request, wb_ack,
               done_valid, done_unit, busy, timeout_err, timeout_unit
    );

endinterface : sp_cmd_issuer_if
`default_nettype wire

// File: rtl/sp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sp_rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting at the priority pointer and returns a one-hot
//               grant plus the granted index.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // First requester at or after the pointer (circularly) wins
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        o_grant  = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand     = (int'(i_ptr) + k) % N;
            cand_idx = IDX_W'(cand);
            if (!o_valid && i_req[cand_idx]) begin
                o_valid           = 1'b1;
                o_grant[cand_idx] = 1'b1;
                o_idx             = cand_idx;
            end
        end
    end

endmodule : sp_rr_arbiter
`default_nettype wire

// File: rtl/sp_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : sp_cmd_issuer
// Description : Issues one command at a time to NUM_UNITS command units,
//               tracks one outstanding command per unit, acknowledges unit
//               completions round-robin and flags the first unit that stays
//               busy for TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_cmd_issuer
    import sp_cmd_pkg::*;
#(
    parameter int NUM_UNITS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           rst,
    sp_cmd_issuer_if.slave bus
);

    localparam int               c_idx_w     = $clog2(NUM_UNITS);
    localparam logic [c_idx_w:0] c_num_units = (c_idx_w + 1)'(NUM_UNITS);

    // Registered state
    logic [NUM_UNITS-1:0] busy_q,       busy_d;
    logic [c_idx_w-1:0]   ptr_q,        ptr_d;
    logic                 done_valid_q, done_valid_d;
    logic [c_idx_w-1:0]   done_unit_q,  done_unit_d;
    busy_cnt_t            cnt_q [NUM_UNITS];
    busy_cnt_t            cnt_d [NUM_UNITS];
    logic                 to_err_q,     to_err_d;
    logic [c_idx_w-1:0]   to_unit_q,    to_unit_d;

    // Combinational
    logic                 w_unit_ok;
    logic                 w_cmd_ready;
    logic                 w_cmd_fire;
    logic [NUM_UNITS-1:0] w_issue;
    logic [NUM_UNITS-1:0] w_wb_req;
    logic [NUM_UNITS-1:0] w_grant;
    logic [c_idx_w-1:0]   w_grant_idx;
    logic                 w_grant_valid;
    logic [NUM_UNITS-1:0] w_to_hit;

    // Accept a command when its (in-range) target is idle and ready
    always_comb begin
        w_unit_ok   = ({1'b0, bus.cmd_unit} < c_num_units);
        w_cmd_ready = 1'b0;
        if (!rst && w_unit_ok) begin
            w_cmd_ready = !busy_q[bus.cmd_unit] && bus.issue_ready[bus.cmd_unit];
        end
        w_cmd_fire = bus.cmd_valid && w_cmd_ready;
        w_issue    = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_cmd_fire && (bus.cmd_unit == c_idx_w'(i))) begin
                w_issue[i] = 1'b1;
            end
        end
    end

    // Only units that actually own a command may be acknowledged
    assign w_wb_req = rst ? '0 : (bus.wb_done & busy_q);

    sp_rr_arbiter #(
        .N     (NUM_UNITS),
        .IDX_W (c_idx_w)
    ) u_wb_arb (
        .i_req   (w_wb_req),
        .i_ptr   (ptr_q),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_valid (w_grant_valid)
    );

    // Busy bitmap, priority pointer and completion report
    always_comb begin
        busy_d       = (busy_q & ~w_grant) | w_issue;
        ptr_d        = ptr_q;
        if (w_grant_valid) begin
            ptr_d = c_idx_w'(wrap_next(unit_idx_t'(w_grant_idx), NUM_UNITS));
        end
        done_valid_d = w_grant_valid;
        done_unit_d  = w_grant_valid ? w_grant_idx : done_unit_q;
    end

    // Per-unit busy-cycle counters; a hit marks the cycle a counter reaches the limit
    always_comb begin
        w_to_hit = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (w_issue[i]) begin
                cnt_d[i] = '0;
            end else if (busy_q[i] && (cnt_q[i] != CNT_SAT)) begin
                cnt_d[i]    = cnt_q[i] + 1'b1;
                w_to_hit[i] = (TIMEOUT_CYCLES != 0) &&
                              ((32'(cnt_q[i]) + 32'd1) == 32'(TIMEOUT_CYCLES));
            end
        end
    end

    // Sticky timeout flag; the lowest-index unit wins a same-cycle tie
    always_comb begin
        to_err_d  = to_err_q;
        to_unit_d = to_unit_q;
        if (!to_err_q && (|w_to_hit)) begin
            to_err_d = 1'b1;
            for (int i = NUM_UNITS - 1; i >= 0; i--) begin
                if (w_to_hit[i]) begin
                    to_unit_d = c_idx_w'(i);
                end
            end
        end
    end

    // State registers; reset abandons every outstanding command
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            ptr_q        <= '0;
            done_valid_q <= 1'b0;
            done_unit_q  <= '0;
            to_err_q     <= 1'b0;
            to_unit_q    <= '0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            ptr_q        <= ptr_d;
            done_valid_q <= done_valid_d;
            done_unit_q  <= done_unit_d;
            to_err_q     <= to_err_d;
            to_unit_q    <= to_unit_d;
            for (int i = 0; i < NUM_UNITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.cmd_ready         = w_cmd_ready;
    assign bus.issue_new_request = w_issue;
    assign bus.wb_ack            = w_grant;
    assign bus.done_valid        = done_valid_q;
    assign bus.done_unit         = done_unit_q;
    assign bus.busy              = busy_q;
    assign bus.timeout_err       = to_err_q;
    assign bus.timeout_unit      = to_unit_q;

endmodule : sp_cmd_issuer
`default_nettype wire

// File: tb/tb_sp_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sp_cmd_issuer
// Description : Self-checking bench for sp_cmd_issuer: directed stimulus,
//               a behavioural reference model compared every cycle, and
//               literal expectations at the key points of each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sp_cmd_issuer;

    localparam int N  = 4;
    localparam int TO = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    sp_cmd_issuer_if #(.NUM_UNITS(N)) bus ();

    sp_cmd_issuer #(
        .NUM_UNITS      (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Reference model: outstanding-command set, round-robin pointer, per-unit
    // busy-cycle counts, pending completion and sticky timeout record.
    bit m_busy [N];
    int m_cnt  [N];
    int m_ptr;
    bit m_done_v;
    int m_done_u;
    bit m_to;
    int m_to_u;

    initial begin
        int         u;
        int         g;
        int         w;
        bit         exp_ready;
        logic [N-1:0] exp_issue;
        logic [N-1:0] exp_ack;
        logic [N-1:0] exp_busy;
        bit         old_busy [N];
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_cnt[i]  = 0;
        end
        m_ptr = 0; m_done_v = 1'b0; m_done_u = 0; m_to = 1'b0; m_to_u = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            u         = int'(bus.cmd_unit);
            exp_ready = !rst && (u < N) && !m_busy[u] && bus.issue_ready[u];
            exp_issue = (bus.cmd_valid && exp_ready) ? N'(1 << u) : '0;
            g = -1;
            if (!rst) begin
                for (int k = 0; k < N; k++) begin
                    w = (m_ptr + k) % N;
                    if (g < 0 && bus.wb_done[w] && m_busy[w]) g = w;
                end
            end
            exp_ack = (g >= 0) ? N'(1 << g) : '0;
            for (int i = 0; i < N; i++) exp_busy[i] = m_busy[i];

            chk("model_cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
            chk("model_issue", 32'(bus.issue_new_request), 32'(exp_issue));
            chk("model_wb_ack", 32'(bus.wb_ack), 32'(exp_ack));
            chk("model_busy", 32'(bus.busy), 32'(exp_busy));
            chk("model_done_valid", 32'(bus.done_valid), 32'(m_done_v));
            if (m_done_v) chk("model_done_unit", 32'(bus.done_unit), 32'(m_done_u));
            chk("model_timeout_err", 32'(bus.timeout_err), 32'(m_to));
            chk("model_timeout_unit", 32'(bus.timeout_unit), 32'(m_to_u));

            // Advance the model across the coming rising edge
            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    m_busy[i] = 1'b0;
                    m_cnt[i]  = 0;
                end
                m_ptr = 0; m_done_v = 1'b0; m_done_u = 0; m_to = 1'b0; m_to_u = 0;
            end else begin
                for (int i = 0; i < N; i++) old_busy[i] = m_busy[i];
                m_done_v = (g >= 0);
                if (g >= 0) begin
                    m_done_u  = g;
                    m_busy[g] = 1'b0;
                    m_ptr     = (g + 1) % N;
                end
                if (exp_issue != '0) begin
                    m_busy[u] = 1'b1;
                    m_cnt[u]  = 0;
                end
                for (int i = 0; i < N; i++) begin
                    if (old_busy[i] && m_cnt[i] < 65535) begin
                        m_cnt[i]++;
                        if (TO != 0 && m_cnt[i] == TO && !m_to) begin
                            m_to   = 1'b1;
                            m_to_u = i;
                        end
                    end
                end
            end
        end
    end

    // Directed stimulus with literal expectations
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_unit    = 2'd2;
        bus.issue_ready = 4'b1111;
        bus.wb_done     = 4'b0000;

        // Reset state, command held off during reset
        at_neg();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done_valid", 32'(bus.done_valid), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);

        // Issue unit 2, then a second command to the same unit stalls
        step(); rst = 1'b0;
        at_neg();
        chk("issue2_ready", 32'(bus.cmd_ready), 32'd1);
        chk("issue2_strobe", 32'(bus.issue_new_request), 32'b0100);
        step();
        at_neg();
        chk("issue2_busy", 32'(bus.busy), 32'b0100);
        chk("issue2_again_ready", 32'(bus.cmd_ready), 32'd0);
        chk("issue2_again_strobe", 32'(bus.issue_new_request), 32'd0);
        step(); bus.cmd_unit = 2'd1;
        step(); bus.cmd_valid = 1'b0;
        at_neg();
        chk("busy_0110", 32'(bus.busy), 32'b0110);

        // Reset with commands outstanding
        step(); rst = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_unit = 2'd0; bus.wb_done = 4'b0110;
        at_neg();
        chk("inrst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("inrst_wb_ack", 32'(bus.wb_ack), 32'd0);
        chk("inrst_strobe", 32'(bus.issue_new_request), 32'd0);
        step(); rst = 1'b0; bus.cmd_valid = 1'b0; bus.wb_done = 4'b0000;
        at_neg();
        chk("postrst_busy", 32'(bus.busy), 32'd0);
        chk("postrst_done_valid", 32'(bus.done_valid), 32'd0);
        chk("postrst_done_unit", 32'(bus.done_unit), 32'd0);

        // All four busy and done: acks rotate 0,1,2,3
        for (int k = 0; k < N; k++) begin
            step(); bus.cmd_valid = 1'b1; bus.cmd_unit = 2'(k);
        end
        step(); bus.cmd_valid = 1'b0; bus.wb_done = 4'b1111;
        for (int k = 0; k < N; k++) begin
            at_neg();
            chk("rr_ack", 32'(bus.wb_ack), 32'(1 << k));
            if (k > 0) begin
                chk("rr_done_valid", 32'(bus.done_valid), 32'd1);
                chk("rr_done_unit", 32'(bus.done_unit), 32'(k - 1));
            end
            step();
        end
        at_neg();
        chk("rr_ack_empty", 32'(bus.wb_ack), 32'd0);
        chk("rr_done_unit3", 32'(bus.done_unit), 32'd3);
        step(); bus.wb_done = 4'b0000;
        at_neg();
        chk("rr_done_clear", 32'(bus.done_valid), 32'd0);

        // Pointer to 3, then wrap 3 -> 0, with a concurrent issue to unit 1
        step(); bus.cmd_valid = 1'b1; bus.cmd_unit = 2'd2;
        step(); bus.cmd_unit = 2'd3; bus.wb_done = 4'b0100;
        at_neg();
        chk("wrap_ack2", 32'(bus.wb_ack), 32'b0100);
        chk("wrap_issue3", 32'(bus.issue_new_request), 32'b1000);
        step(); bus.cmd_unit = 2'd0; bus.wb_done = 4'b0000;
        step(); bus.cmd_unit = 2'd1; bus.wb_done = 4'b1001;
        at_neg();
        chk("wrap_ack3", 32'(bus.wb_ack), 32'b1000);
        chk("concurrent_issue1", 32'(bus.issue_new_request), 32'b0010);
        step(); bus.cmd_valid = 1'b0;
        at_neg();
        chk("wrap_ack0", 32'(bus.wb_ack), 32'b0001);
        chk("wrap_done3", 32'(bus.done_unit), 32'd3);
        chk("concurrent_busy", 32'(bus.busy), 32'b0011);
        step(); bus.wb_done = 4'b0010;
        at_neg();
        chk("wrap_ack1", 32'(bus.wb_ack), 32'b0010);
        step(); bus.wb_done = 4'b0000;
        at_neg();
        chk("wrap_idle_busy", 32'(bus.busy), 32'd0);

        // Completion on an idle unit is ignored
        step(); bus.wb_done = 4'b0010;
        at_neg();
        chk("idle_wb_ack", 32'(bus.wb_ack), 32'd0);
        step(); bus.wb_done = 4'b0000;
        at_neg();
        chk("idle_done_valid", 32'(bus.done_valid), 32'd0);

        // Timeout on unit 1 after 8 busy cycles; ack still works; flag sticks
        step(); bus.cmd_valid = 1'b1; bus.cmd_unit = 2'd1;
        step(); bus.cmd_valid = 1'b0;
        repeat (TO - 1) step();
        at_neg();
        chk("to_not_yet", 32'(bus.timeout_err), 32'd0);
        step();
        at_neg();
        chk("to_err", 32'(bus.timeout_err), 32'd1);
        chk("to_unit", 32'(bus.timeout_unit), 32'd1);
        step(); bus.wb_done = 4'b0010;
        at_neg();
        chk("to_ack", 32'(bus.wb_ack), 32'b0010);
        step(); bus.wb_done = 4'b0000;
        at_neg();
        chk("to_busy_cleared", 32'(bus.busy), 32'd0);
        chk("to_sticky", 32'(bus.timeout_err), 32'd1);
        chk("to_unit_sticky", 32'(bus.timeout_unit), 32'd1);

        // Reset clears the sticky flag
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        at_neg();
        chk("final_to_err", 32'(bus.timeout_err), 32'd0);
        chk("final_to_unit", 32'(bus.timeout_unit), 32'd0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Time bound on the whole run
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_sp_cmd_issuer
`default_nettype wire
